// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the register-file writeback scheduler.
//   AW/DW      : register address / data width
//   NREG       : number of architectural registers (pending scoreboard width)
//   DEPTH      : src1 holding FIFO entries (power of 2, >= 2)
//   MAX_OUT    : max mul/div ops issued but not yet committed
//   wb_src_e   : which source owns the write-port slot loaded this cycle
//   wb_entry_t : one queued src1 result {rd, data}
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int AW      = 5;
    localparam int DW      = 32;
    localparam int NREG    = 32;
    localparam int DEPTH   = 2;
    localparam int MAX_OUT = 4;

    // Counter widths sized to hold the inclusive maximum value.
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_S0   = 2'd1,
        WB_S1   = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage : regfile_pkg

// File: rtl/wb_skid_fifo.sv
// ----------------------------------------------------------------------------
// wb_skid_fifo
//   Small circular FIFO that holds src1 results while src0 owns the
//   register-file write port. Head is presented combinationally (show-ahead).
//   Ports:
//     clk      in   clock
//     rst_n    in   async active-low reset (flushes pointers and count)
//     push_i   in   write din_i at tail (caller guarantees not full)
//     din_i    in   W-bit entry
//     pop_i    in   drop head (caller guarantees not empty)
//     dout_o   out  head entry
//     count_o  out  number of valid entries
//     empty_o  out  count_o == 0
// ----------------------------------------------------------------------------
module wb_skid_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dout_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been pushed.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule : wb_skid_fifo

// File: rtl/regfile_wb_scheduler.sv
// ----------------------------------------------------------------------------
// regfile_wb_scheduler
//   Arbitrates the register file's single write port between the in-order
//   ALU/load pipeline (src0, no backpressure, absolute priority) and the
//   multi-cycle mul/div unit (src1, valid/ready, buffered in a small FIFO).
//   Tracks outstanding mul/div destinations in a pending scoreboard and
//   raises raw_stall when a decode source register is still in flight.
//   Ports:
//     clk, rst_n                        clock, async active-low reset
//     issue_valid/issue_rd/issue_ready  mul/div issue into the scoreboard
//     s0_we/s0_rd/s0_data               src0 writeback
//     s1_valid/s1_ready/s1_rd/s1_data   src1 writeback handshake
//     rf_we/rf_wa/rf_wd                 registered register-file write port
//     chk_ra1/chk_ra2/raw_stall         decode hazard check (combinational)
// ----------------------------------------------------------------------------
module regfile_wb_scheduler
    import regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    output logic          issue_ready,
    input  logic          s0_we,
    input  logic [AW-1:0] s0_rd,
    input  logic [DW-1:0] s0_data,
    input  logic          s1_valid,
    output logic          s1_ready,
    input  logic [AW-1:0] s1_rd,
    input  logic [DW-1:0] s1_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    input  logic [AW-1:0] chk_ra1,
    input  logic [AW-1:0] chk_ra2,
    output logic          raw_stall
);

    logic            rf_we_q,     rf_we_d;
    logic [AW-1:0]   rf_wa_q,     rf_wa_d;
    logic [DW-1:0]   rf_wd_q,     rf_wd_d;
    wb_src_e         src_q,       src_d;
    logic            s1_ready_q,  s1_ready_d;
    logic [NREG-1:0] pending_q,   pending_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;

    logic            s1_hs;
    logic            issue_acc;
    logic            commit;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   fifo_count_nxt;
    wb_entry_t       fifo_head;
    wb_entry_t       fifo_din;

    assign s1_hs     = s1_valid && s1_ready_q;
    assign issue_acc = issue_valid && issue_ready;
    // The slot loaded last cycle came from src1, so this edge is the one the
    // register file latches it on: retire it from the scoreboard now.
    assign commit    = (src_q == WB_S1);
    assign fifo_din  = '{rd: s1_rd, data: s1_data};

    wb_skid_fifo #(
        .W     (AW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    // Write-port mux. rf_wa/rf_wd hold their value on idle cycles; a src1
    // rd==0 entry still takes the slot (and commits) but leaves rf_we low.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_wa_d   = rf_wa_q;
        rf_wd_d   = rf_wd_q;
        src_d     = WB_NONE;
        fifo_pop  = 1'b0;
        fifo_push = s1_hs;
        if (s0_we && (s0_rd != '0)) begin
            rf_we_d = 1'b1;
            rf_wa_d = s0_rd;
            rf_wd_d = s0_data;
            src_d   = WB_S0;
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            rf_we_d  = (fifo_head.rd != '0);
            rf_wa_d  = fifo_head.rd;
            rf_wd_d  = fifo_head.data;
            src_d    = WB_S1;
        end else if (s1_hs) begin
            fifo_push = 1'b0;
            rf_we_d   = (s1_rd != '0);
            rf_wa_d   = s1_rd;
            rf_wd_d   = s1_data;
            src_d     = WB_S1;
        end
    end

    // s1_ready is registered from the next-cycle FIFO occupancy so it always
    // equals (fifo_count < DEPTH) without a combinational path to s1_valid.
    always_comb begin
        unique case ({fifo_push, fifo_pop})
            2'b10:   fifo_count_nxt = fifo_count + CW'(1);
            2'b01:   fifo_count_nxt = fifo_count - CW'(1);
            default: fifo_count_nxt = fifo_count;
        endcase
        s1_ready_d = (fifo_count_nxt < CW'(DEPTH));
    end

    // Scoreboard: clear first, then set, so a same-edge issue wins.
    always_comb begin
        pending_d = pending_q;
        if (commit) begin
            pending_d[rf_wa_q] = 1'b0;
        end
        if (issue_acc && (issue_rd != '0)) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Outstanding counter; the zero guard keeps a protocol-violating commit
    // from wrapping the count.
    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({issue_acc, commit})
            2'b10: outstanding_d = outstanding_q + OW'(1);
            2'b01: begin
                if (outstanding_q != '0) begin
                    outstanding_d = outstanding_q - OW'(1);
                end
            end
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q       <= 1'b0;
            rf_wa_q       <= '0;
            rf_wd_q       <= '0;
            src_q         <= WB_NONE;
            s1_ready_q    <= 1'b1;
            pending_q     <= '0;
            outstanding_q <= '0;
        end else begin
            rf_we_q       <= rf_we_d;
            rf_wa_q       <= rf_wa_d;
            rf_wd_q       <= rf_wd_d;
            src_q         <= src_d;
            s1_ready_q    <= s1_ready_d;
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_wa       = rf_wa_q;
    assign rf_wd       = rf_wd_q;
    assign s1_ready    = s1_ready_q;
    assign issue_ready = (outstanding_q < OW'(MAX_OUT));
    assign raw_stall   = pending_q[chk_ra1] | pending_q[chk_ra2];

endmodule : regfile_wb_scheduler

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;
    import regfile_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          issue_ready;
    logic          s0_we;
    logic [AW-1:0] s0_rd;
    logic [DW-1:0] s0_data;
    logic          s1_valid;
    logic          s1_ready;
    logic [AW-1:0] s1_rd;
    logic [DW-1:0] s1_data;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [AW-1:0] chk_ra1;
    logic [AW-1:0] chk_ra2;
    logic          raw_stall;

    regfile_wb_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .s0_we       (s0_we),
        .s0_rd       (s0_rd),
        .s0_data     (s0_data),
        .s1_valid    (s1_valid),
        .s1_ready    (s1_ready),
        .s1_rd       (s1_rd),
        .s1_data     (s1_data),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .chk_ra1     (chk_ra1),
        .chk_ra2     (chk_ra2),
        .raw_stall   (raw_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: write port as a priority choice, FIFO as a queue,
    // scoreboard as a bit array and an integer count.
    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          m_q[$];
    bit [31:0]     m_pend;
    int            m_out;
    bit            m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    bit            m_slot_s1;
    logic [AW-1:0] m_slot_rd;

    task automatic model_reset();
        m_q.delete();
        m_pend    = '0;
        m_out     = 0;
        m_we      = 0;
        m_wa      = '0;
        m_wd      = '0;
        m_slot_s1 = 0;
        m_slot_rd = '0;
    endtask

    // One clock cycle: called just after a falling edge, returns after the next.
    task automatic step(input bit s0w, input logic [AW-1:0] s0r, input logic [DW-1:0] s0d,
                        input bit s1v, input logic [AW-1:0] s1r, input logic [DW-1:0] s1d,
                        input bit iv, input logic [AW-1:0] ir,
                        input logic [AW-1:0] c1, input logic [AW-1:0] c2,
                        output bit hs);
        bit   iss;
        ent_t e;
        s0_we = s0w; s0_rd = s0r; s0_data = s0d;
        s1_valid = s1v; s1_rd = s1r; s1_data = s1d;
        issue_valid = iv; issue_rd = ir;
        chk_ra1 = c1; chk_ra2 = c2;
        #1;
        check_val("raw_stall", raw_stall, m_pend[c1] | m_pend[c2]);
        check_val("s1_ready", s1_ready, m_q.size() < DEPTH);
        check_val("issue_ready", issue_ready, m_out < MAX_OUT);
        hs  = s1v && (m_q.size() < DEPTH);
        iss = iv && (m_out < MAX_OUT);
        if (m_slot_s1) begin
            check_val("commit_outstanding", m_out != 0, 1'b1);
            if (m_out > 0) m_out--;
            m_pend[m_slot_rd] = 1'b0;
        end
        if (iss) begin
            m_out++;
            if (ir != 0) m_pend[ir] = 1'b1;
        end
        m_we = 0;
        m_slot_s1 = 0;
        if (s0w && s0r != 0) begin
            m_we = 1; m_wa = s0r; m_wd = s0d;
            if (hs) m_q.push_back('{s1r, s1d});
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_slot_s1 = 1; m_slot_rd = e.rd;
            m_we = (e.rd != 0); m_wa = e.rd; m_wd = e.data;
            if (hs) m_q.push_back('{s1r, s1d});
        end else if (hs) begin
            m_slot_s1 = 1; m_slot_rd = s1r;
            m_we = (s1r != 0); m_wa = s1r; m_wd = s1d;
        end
        @(posedge clk);
        @(negedge clk);
        check_val("rf_we", rf_we, m_we);
        if (m_we) begin
            check_val("rf_wa", rf_wa, m_wa);
            check_val("rf_wd", rf_wd, m_wd);
        end
    endtask

    task automatic idle(input logic [AW-1:0] c1);
        bit hs;
        step(0, 0, 0, 0, 0, 0, 0, 0, c1, 0, hs);
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        bit hs;
        step(0, 0, 0, 0, 0, 0, 1, rd, rd, 0, hs);
    endtask

    // Present one src1 result until accepted, bounded.
    task automatic deliver(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        bit hs;
        int n;
        hs = 0;
        n  = 0;
        while (!hs && n < 20) begin
            step(0, 0, 0, 1, rd, d, 0, 0, rd, 0, hs);
            n++;
        end
        check_val("deliver_hs", hs, 1'b1);
    endtask

    // Asserts reset mid-cycle (away from any edge) and checks outputs at once.
    task automatic apply_reset();
        #3 rst_n = 1'b0;
        #1;
        check_val("rst_rf_we", rf_we, 1'b0);
        check_val("rst_rf_wa", rf_wa, 0);
        check_val("rst_rf_wd", rf_wd, 0);
        check_val("rst_s1_ready", s1_ready, 1'b1);
        check_val("rst_issue_ready", issue_ready, 1'b1);
        check_val("rst_raw_stall", raw_stall, 1'b0);
        s0_we = 0; s1_valid = 0; issue_valid = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit            hs;
        bit            acc;
        int            idx;
        int            mo_q[$];
        bit            s1v_h;
        logic [AW-1:0] s1r_h;
        logic [DW-1:0] s1d_h;
        bit            iv, s0w;
        logic [AW-1:0] ir, s0r;
        logic [DW-1:0] s0d;

        rst_n = 1'b1;
        issue_valid = 0; issue_rd = 0; s0_we = 0; s0_rd = 0; s0_data = 0;
        s1_valid = 0; s1_rd = 0; s1_data = 0; chk_ra1 = 0; chk_ra2 = 0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // src0 single write, one-cycle latency
        step(1, 3, 32'hA5, 0, 0, 0, 0, 0, 0, 0, hs);
        check_val("t1_we", rf_we, 1'b1);
        check_val("t1_wa", rf_wa, 3);
        check_val("t1_wd", rf_wd, 32'hA5);
        idle(0);
        check_val("t1_we_off", rf_we, 1'b0);

        // issue -> pending -> bypass write -> cleared on commit edge
        issue(5);
        check_val("t2_stall_set", raw_stall, 1'b1);
        step(0, 0, 0, 1, 5, 32'h1234, 0, 0, 5, 0, hs);
        check_val("t2_we", rf_we, 1'b1);
        check_val("t2_wa", rf_wa, 5);
        check_val("t2_wd", rf_wd, 32'h1234);
        check_val("t2_stall_hold", raw_stall, 1'b1);
        idle(5);
        check_val("t2_stall_clr", raw_stall, 1'b0);

        // src0 hogs the port while src1 offers three results
        issue(7); issue(8); issue(9);
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            step(1, 5'(10 + k), 32'hC000 + k, idx < 3, 5'(7 + idx), 32'hD000 + idx, 0, 0, 7, 9, hs);
            if (hs) idx++;
        end
        check_val("t3_accepted", idx, 2);
        check_val("t3_s1_ready", s1_ready, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, idx < 3, 5'(7 + idx), 32'hD000 + idx, 0, 0, 8, 9, hs);
            if (hs) idx++;
        end
        check_val("t3_all_in", idx, 3);

        // rd==0 on both sources: no write, but the src1 slot still commits
        issue(0); issue(20); issue(21); issue(22);
        check_val("t5_full", issue_ready, 1'b0);
        step(1, 0, 32'hBAD, 1, 0, 32'hBAD1, 0, 0, 0, 0, hs);
        check_val("t5_no_we", rf_we, 1'b0);
        idle(0);
        check_val("t5_no_we2", rf_we, 1'b0);
        check_val("t5_freed", issue_ready, 1'b1);
        deliver(20, 32'h20); deliver(21, 32'h21); deliver(22, 32'h22);
        idle(0); idle(0);

        // issue limit and same-edge set/clear
        issue(1); issue(2); issue(3); issue(4);
        check_val("t4_limit", issue_ready, 1'b0);
        issue(9);
        check_val("t4_ignored", raw_stall, 1'b0);
        step(0, 0, 0, 1, 1, 32'h11, 0, 0, 1, 0, hs);
        idle(1);
        check_val("t4_after_commit", issue_ready, 1'b1);
        step(0, 0, 0, 1, 2, 32'h22, 0, 0, 2, 0, hs);
        step(0, 0, 0, 0, 0, 0, 1, 2, 2, 0, hs);
        check_val("t4_set_wins", raw_stall, 1'b1);
        check_val("t4_count_kept", issue_ready, 1'b1);
        deliver(2, 32'h222); deliver(3, 32'h33); deliver(4, 32'h44);
        idle(0); idle(0);

        // randomized traffic against the model
        s1v_h = 0; s1r_h = 0; s1d_h = 0;
        for (int k = 0; k < 1500; k++) begin
            iv  = ($urandom_range(0, 99) < 30);
            ir  = 5'($urandom_range(0, 31));
            acc = iv && (m_out < MAX_OUT);
            if (!s1v_h && mo_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                s1v_h = 1;
                s1r_h = 5'(mo_q.pop_front());
                s1d_h = $urandom;
            end
            s0w = ($urandom_range(0, 99) < 45);
            s0r = 5'($urandom_range(0, 31));
            s0d = $urandom;
            step(s0w, s0r, s0d, s1v_h, s1r_h, s1d_h, iv, ir,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), hs);
            if (hs) s1v_h = 0;
            if (acc) mo_q.push_back(int'(ir));
        end
        for (int k = 0; k < 80; k++) begin
            if (!s1v_h && mo_q.size() > 0) begin
                s1v_h = 1;
                s1r_h = 5'(mo_q.pop_front());
                s1d_h = $urandom;
            end
            if (!s1v_h && m_out == 0 && m_q.size() == 0 && !m_slot_s1) break;
            step(0, 0, 0, s1v_h, s1r_h, s1d_h, 0, 0, 5'($urandom_range(0, 31)), 0, hs);
            if (hs) s1v_h = 0;
        end
        check_val("drain_ready", issue_ready, 1'b1);

        // async reset mid-burst with FIFO full and 3 outstanding
        issue(11); issue(12); issue(13);
        idx = 0;
        for (int k = 0; k < 3; k++) begin
            step(1, 14, 32'hE000 + k, idx < 2, 5'(11 + idx), 32'hF000 + idx, 0, 0, 11, 13, hs);
            if (hs) idx++;
        end
        check_val("t6_fifo_full", s1_ready, 1'b0);
        check_val("t6_stall_before", raw_stall, 1'b1);
        apply_reset();
        idle(11);
        idle(13);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule : tb_regfile_wb_scheduler
